// File: rtl/serial_cmp_decoder.sv
// Decodes an MSB-first stream of one-cold per-bit compare codes into a word-level
// magnitude result, flagging illegal codes and malformed frames.
module serial_cmp_decoder #(
  parameter int MAX_BITS = 16,
  parameter int LEN_W    = 5
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             code_valid,
  input  logic             code_first,
  input  logic             code_last,
  input  logic [2:0]       code_in,
  output logic             res_valid,
  output logic [2:0]       res_code,
  output logic             res_lt,
  output logic             res_eq,
  output logic             res_gt,
  output logic [LEN_W-1:0] res_len,
  output logic             res_illegal,
  output logic             err_frame,
  output logic             busy
);

  localparam logic [2:0] CODE_LT   = 3'b011;
  localparam logic [2:0] CODE_EQ   = 3'b101;
  localparam logic [2:0] CODE_GT   = 3'b110;
  localparam logic [2:0] CODE_NONE = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic code_is_legal(input logic [2:0] c);
    return (c == CODE_LT) || (c == CODE_EQ) || (c == CODE_GT);
  endfunction

  function automatic logic code_is_decisive(input logic [2:0] c);
    return (c == CODE_LT) || (c == CODE_GT);
  endfunction

  state_t             state_q, state_d;
  logic               decided_q, decided_d;
  logic [2:0]         held_q, held_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               ill_q, ill_d;
  logic               res_valid_q, res_valid_d;
  logic [2:0]         res_code_q, res_code_d;
  logic               res_lt_q, res_lt_d;
  logic               res_eq_q, res_eq_d;
  logic               res_gt_q, res_gt_d;
  logic [LEN_W-1:0]   res_len_q, res_len_d;
  logic               res_ill_q, res_ill_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;

  logic               fresh_s;
  logic               base_decided_s;
  logic [2:0]         base_held_s;
  logic [LEN_W-1:0]   base_cnt_s;
  logic               base_ill_s;
  logic               beat_decided_s;
  logic [2:0]         beat_held_s;
  logic [LEN_W-1:0]   beat_cnt_s;
  logic               beat_ill_s;
  logic               overflow_s;
  logic               accept_s;

  // Frame context the current beat builds on, and that context after decoding the beat
  always_comb begin
    fresh_s = (state_q == ST_IDLE) || code_first;
    if (fresh_s) begin
      base_decided_s = 1'b0;
      base_held_s    = CODE_EQ;
      base_cnt_s     = {LEN_W{1'b0}};
      base_ill_s     = 1'b0;
    end else begin
      base_decided_s = decided_q;
      base_held_s    = held_q;
      base_cnt_s     = cnt_q;
      base_ill_s     = ill_q;
    end
    beat_decided_s = base_decided_s | code_is_decisive(code_in);
    if (!base_decided_s && code_is_decisive(code_in)) begin
      beat_held_s = code_in;
    end else begin
      beat_held_s = base_held_s;
    end
    beat_cnt_s = base_cnt_s + LEN_W'(1'b1);
    beat_ill_s = base_ill_s | ~code_is_legal(code_in);
    overflow_s = (state_q == ST_RUN) && !code_first && (cnt_q == LEN_W'(MAX_BITS));
  end

  // Frame FSM next-state, result capture and error pulse
  always_comb begin
    state_d     = state_q;
    decided_d   = decided_q;
    held_d      = held_q;
    cnt_d       = cnt_q;
    ill_d       = ill_q;
    res_valid_d = 1'b0;
    res_code_d  = res_code_q;
    res_lt_d    = res_lt_q;
    res_eq_d    = res_eq_q;
    res_gt_d    = res_gt_q;
    res_len_d   = res_len_q;
    res_ill_d   = res_ill_q;
    err_d       = 1'b0;
    accept_s    = 1'b0;

    if (code_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (code_first) begin
            accept_s = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        ST_RUN: begin
          if (code_first) begin
            err_d    = 1'b1;
            accept_s = 1'b1;
          end else if (overflow_s) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            accept_s = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      accept_s = 1'b0;
    end

    // An accepted last beat closes the frame and publishes the result next cycle
    if (accept_s) begin
      decided_d = beat_decided_s;
      held_d    = beat_held_s;
      cnt_d     = beat_cnt_s;
      ill_d     = beat_ill_s;
      if (code_last) begin
        state_d     = ST_IDLE;
        res_valid_d = 1'b1;
        res_code_d  = beat_held_s;
        res_lt_d    = (beat_held_s == CODE_LT);
        res_eq_d    = (beat_held_s == CODE_EQ);
        res_gt_d    = (beat_held_s == CODE_GT);
        res_len_d   = beat_cnt_s;
        res_ill_d   = beat_ill_s;
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      cnt_d = cnt_q;
    end

    busy_d = (state_d == ST_RUN);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      decided_q   <= 1'b0;
      held_q      <= CODE_EQ;
      cnt_q       <= {LEN_W{1'b0}};
      ill_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_code_q  <= CODE_NONE;
      res_lt_q    <= 1'b0;
      res_eq_q    <= 1'b0;
      res_gt_q    <= 1'b0;
      res_len_q   <= {LEN_W{1'b0}};
      res_ill_q   <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      decided_q   <= decided_d;
      held_q      <= held_d;
      cnt_q       <= cnt_d;
      ill_q       <= ill_d;
      res_valid_q <= res_valid_d;
      res_code_q  <= res_code_d;
      res_lt_q    <= res_lt_d;
      res_eq_q    <= res_eq_d;
      res_gt_q    <= res_gt_d;
      res_len_q   <= res_len_d;
      res_ill_q   <= res_ill_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign res_valid   = res_valid_q;
  assign res_code    = res_code_q;
  assign res_lt      = res_lt_q;
  assign res_eq      = res_eq_q;
  assign res_gt      = res_gt_q;
  assign res_len     = res_len_q;
  assign res_illegal = res_ill_q;
  assign err_frame   = err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_serial_cmp_decoder.sv
// Bench for serial_cmp_decoder: a frame-level reference model (queue of beats per frame)
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_serial_cmp_decoder;

  localparam int MAX_BITS = 16;
  localparam int LEN_W    = 5;
  localparam logic [2:0] LT = 3'b011;
  localparam logic [2:0] EQ = 3'b101;
  localparam logic [2:0] GT = 3'b110;

  logic             sys_clk = 1'b0;
  logic             sys_rst = 1'b1;
  logic             code_valid = 1'b0;
  logic             code_first = 1'b0;
  logic             code_last = 1'b0;
  logic [2:0]       code_in = 3'b101;
  logic             res_valid;
  logic [2:0]       res_code;
  logic             res_lt, res_eq, res_gt;
  logic [LEN_W-1:0] res_len;
  logic             res_illegal;
  logic             err_frame;
  logic             busy;

  int checks = 0;
  int errors = 0;

  serial_cmp_decoder #(.MAX_BITS(MAX_BITS), .LEN_W(LEN_W)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .code_valid(code_valid), .code_first(code_first), .code_last(code_last),
    .code_in(code_in),
    .res_valid(res_valid), .res_code(res_code),
    .res_lt(res_lt), .res_eq(res_eq), .res_gt(res_gt),
    .res_len(res_len), .res_illegal(res_illegal),
    .err_frame(err_frame), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: collects the open frame's beats and evaluates the word result on close
  bit         model_ready = 1'b0;
  bit         open = 1'b0;
  logic [2:0] frm[$];
  logic       exp_valid = 1'b0, exp_err = 1'b0, exp_busy = 1'b0, exp_ill = 1'b0;
  logic       exp_lt = 1'b0, exp_eq = 1'b0, exp_gt = 1'b0;
  logic [2:0] exp_code = 3'b111;
  int         exp_len = 0;

  always @(posedge sys_clk) begin
    logic [2:0] r;
    logic       ill;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    if (sys_rst) begin
      model_ready = 1'b1;
      open = 1'b0;
      frm.delete();
      exp_code = 3'b111; exp_lt = 1'b0; exp_eq = 1'b0; exp_gt = 1'b0;
      exp_len = 0; exp_ill = 1'b0;
    end else if (code_valid) begin
      if (code_first) begin
        if (open) exp_err = 1'b1;
        frm.delete();
        frm.push_back(code_in);
        open = 1'b1;
      end else if (!open) begin
        exp_err = 1'b1;
      end else if (frm.size() >= MAX_BITS) begin
        exp_err = 1'b1;
        open = 1'b0;
        frm.delete();
      end else begin
        frm.push_back(code_in);
      end
      if (open && code_last) begin
        r = EQ;
        ill = 1'b0;
        foreach (frm[k]) begin
          if (r == EQ && (frm[k] == LT || frm[k] == GT)) r = frm[k];
          if (!(frm[k] == LT || frm[k] == EQ || frm[k] == GT)) ill = 1'b1;
        end
        exp_valid = 1'b1;
        exp_code = r;
        exp_lt = (r == LT); exp_eq = (r == EQ); exp_gt = (r == GT);
        exp_len = frm.size();
        exp_ill = ill;
        open = 1'b0;
      end
    end
    exp_busy = open;
  end

  // Compare every output against the model on the falling edge
  always @(negedge sys_clk) begin
    if (model_ready) begin
      chk("res_valid", 32'(res_valid), 32'(exp_valid));
      chk("res_code", 32'(res_code), 32'(exp_code));
      chk("res_lt", 32'(res_lt), 32'(exp_lt));
      chk("res_eq", 32'(res_eq), 32'(exp_eq));
      chk("res_gt", 32'(res_gt), 32'(exp_gt));
      chk("res_len", 32'(res_len), 32'(exp_len));
      chk("res_illegal", 32'(res_illegal), 32'(exp_ill));
      chk("err_frame", 32'(err_frame), 32'(exp_err));
      chk("busy", 32'(busy), 32'(exp_busy));
    end
  end

  task automatic beat(input logic v, input logic f, input logic l, input logic [2:0] c);
    code_valid = v;
    code_first = f;
    code_last  = l;
    code_in    = c;
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    logic [2:0] legal[3];
    legal[0] = LT; legal[1] = EQ; legal[2] = GT;

    sys_rst = 1'b1;
    beat(1'b1, 1'b1, 1'b1, GT);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_code", 32'(res_code), 32'h7);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_len", 32'(res_len), 32'd0);
    sys_rst = 1'b0;
    beat(1'b0, 1'b0, 1'b0, EQ);

    // EQ,EQ,GT,LT -> GT, length 4
    beat(1'b1, 1'b1, 1'b0, EQ);
    beat(1'b1, 1'b0, 1'b0, EQ);
    beat(1'b1, 1'b0, 1'b0, GT);
    beat(1'b1, 1'b0, 1'b1, LT);
    chk("f4_valid", 32'(res_valid), 32'd1);
    chk("f4_code", 32'(res_code), 32'h6);
    chk("f4_gt", 32'(res_gt), 32'd1);
    chk("f4_len", 32'(res_len), 32'd4);
    chk("f4_ill", 32'(res_illegal), 32'd0);
    beat(1'b0, 1'b1, 1'b1, LT);
    chk("hold_valid", 32'(res_valid), 32'd0);
    chk("hold_code", 32'(res_code), 32'h6);

    beat(1'b1, 1'b1, 1'b1, LT);
    chk("single_code", 32'(res_code), 32'h3);
    chk("single_lt", 32'(res_lt), 32'd1);
    chk("single_len", 32'(res_len), 32'd1);

    for (int i = 0; i < 16; i++) beat(1'b1, i == 0, i == 15, EQ);
    chk("max_code", 32'(res_code), 32'h5);
    chk("max_eq", 32'(res_eq), 32'd1);
    chk("max_len", 32'(res_len), 32'd16);

    for (int i = 0; i < 17; i++) begin
      beat(1'b1, i == 0, 1'b0, EQ);
      if (i == 15) chk("ovf_busy16", 32'(busy), 32'd1);
    end
    chk("ovf_err", 32'(err_frame), 32'd1);
    chk("ovf_busy", 32'(busy), 32'd0);
    chk("ovf_valid", 32'(res_valid), 32'd0);
    beat(1'b0, 1'b0, 1'b0, EQ);
    chk("ovf_err_pulse", 32'(err_frame), 32'd0);

    beat(1'b1, 1'b1, 1'b0, EQ);
    beat(1'b1, 1'b0, 1'b0, 3'b000);
    beat(1'b1, 1'b0, 1'b1, LT);
    chk("ill_code", 32'(res_code), 32'h3);
    chk("ill_flag", 32'(res_illegal), 32'd1);
    chk("ill_len", 32'(res_len), 32'd3);

    beat(1'b1, 1'b0, 1'b0, GT);
    chk("idle_err", 32'(err_frame), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    beat(1'b1, 1'b1, 1'b0, GT);
    beat(1'b1, 1'b0, 1'b0, EQ);
    beat(1'b1, 1'b1, 1'b0, EQ);
    chk("restart_err", 32'(err_frame), 32'd1);
    chk("restart_busy", 32'(busy), 32'd1);
    beat(1'b1, 1'b0, 1'b1, LT);
    chk("restart_code", 32'(res_code), 32'h3);
    chk("restart_len", 32'(res_len), 32'd2);

    beat(1'b1, 1'b1, 1'b0, GT);
    sys_rst = 1'b1;
    beat(1'b1, 1'b0, 1'b1, LT);
    sys_rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_code", 32'(res_code), 32'h7);
    chk("midrst_valid", 32'(res_valid), 32'd0);

    beat(1'b1, 1'b1, 1'b1, GT);
    chk("b2b_v1", 32'(res_valid), 32'd1);
    chk("b2b_c1", 32'(res_code), 32'h6);
    beat(1'b1, 1'b1, 1'b1, LT);
    chk("b2b_v2", 32'(res_valid), 32'd1);
    chk("b2b_c2", 32'(res_code), 32'h3);

    for (int i = 0; i < 4000; i++) begin
      sys_rst = ($urandom % 150) == 0;
      beat(($urandom % 10) < 8, ($urandom % 7) == 0, ($urandom % 6) == 0,
           (($urandom % 10) < 8) ? legal[$urandom % 3] : 3'($urandom % 8));
    end
    sys_rst = 1'b0;
    beat(1'b0, 1'b0, 1'b0, EQ);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
